// File: rtl/multu_hilo.sv
// ---------------------------------------------------------------------------
// multu_hilo -- sequential shift-add multiplier with MIPS-style HI/LO registers
//
// Purpose:
//   Accepts MULTU (and optionally MULT) and produces a 2*WIDTH-bit product.
//   The product is built one bit per cycle over WIDTH cycles, then written
//   into HI/LO. MFHI/MFLO read the registers back through a registered
//   result port that feeds the ALU result mux.
//
// Ports:
//   clk      in   single clock, rising-edge
//   reset    in   synchronous, active-high reset
//   dataA    in   WIDTH  multiplicand, sampled on acceptance
//   dataB    in   WIDTH  multiplier, sampled on acceptance
//   Signal   in   6      function code (MULTU/MULT/MFHI/MFLO)
//   dataOut  out  WIDTH  registered HI/LO read result (0 for other codes)
//   busy     out  1      high while a multiply is running
//   done     out  1      one-cycle pulse after HI/LO have been updated
//
// Configuration:
//   MULT_SIGNED_EN  when defined, MULT is accepted as a signed multiply
//                   (magnitude multiply plus a final negate). When undefined,
//                   MULT is an unrecognised code and is ignored.
// ---------------------------------------------------------------------------
module multu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_product;
  logic [CNT_W-1:0]   r_count;
  logic               r_sign;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_dataOut;

  logic               w_isMultu;
  logic               w_isMult;
  logic               w_accept;
  logic               w_lastStep;
  logic [WIDTH-1:0]   w_opA;
  logic [WIDTH-1:0]   w_opB;
  logic               w_signNext;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_sum;
  logic [2*WIDTH-1:0] w_final;

  assign w_isMultu = (Signal == MULTU);

  // Signed support: multiply magnitudes and remember the result sign so the
  // same unsigned datapath and latency serve both MULT and MULTU.
`ifdef MULT_SIGNED_EN
  assign w_isMult   = (Signal == MULT);
  assign w_opA      = (w_isMult && dataA[WIDTH-1]) ? (~dataA + 1'b1) : dataA;
  assign w_opB      = (w_isMult && dataB[WIDTH-1]) ? (~dataB + 1'b1) : dataB;
  assign w_signNext = w_isMult & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
`else
  assign w_isMult   = 1'b0;
  assign w_opA      = dataA;
  assign w_opB      = dataB;
  assign w_signNext = 1'b0;
`endif

  // A new operation can only start outside RUN; anything arriving mid-run
  // is dropped so the running multiply finishes untouched.
  assign w_accept   = (r_state != RUN) && (w_isMultu || w_isMult);
  assign w_lastStep = (r_count == LAST_COUNT);

  // One shift-add step: the sum includes the current bit, so on the final
  // step it already is the complete product and can go straight to HI/LO.
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_sum    = r_product + w_addend;
  assign w_final  = r_sign ? (~w_sum + 1'b1) : w_sum;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: DONE lasts a single cycle but may chain straight into
  // another RUN when a new multiply is accepted during it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = RUN;
      RUN:     if (w_lastStep) w_nextState = DONE;
      DONE:    w_nextState = w_accept ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Multiplier datapath and HI/LO. HI/LO are written only on the last RUN
  // step, so a reset mid-run abandons the operation without touching them
  // beyond the reset clear itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_count   <= '0;
      r_sign    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (w_accept) begin
      r_mcand   <= {{WIDTH{1'b0}}, w_opA};
      r_mplier  <= w_opB;
      r_product <= '0;
      r_count   <= '0;
      r_sign    <= w_signNext;
    end else if (r_state == RUN) begin
      r_product <= w_sum;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= r_mplier >> 1;
      r_count   <= r_count + 1'b1;
      if (w_lastStep) begin
        r_hi <= w_final[2*WIDTH-1:WIDTH];
        r_lo <= w_final[WIDTH-1:0];
      end
    end
  end

  // Read port: registered every cycle, one-cycle latency. A read issued in
  // DONE sees the freshly written HI/LO since they were loaded at the edge
  // that entered DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataOut <= '0;
    end else begin
      case (Signal)
        MFHI:    r_dataOut <= r_hi;
        MFLO:    r_dataOut <= r_lo;
        default: r_dataOut <= '0;
      endcase
    end
  end

  assign dataOut = r_dataOut;
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: doc/multu_hilo.md
MULTU_HILO -- requirements
Module: multu_hilo

Interface
REQ-001 Parameter: WIDTH, 32, operand width; the product is 2*WIDTH bits, split across HI and LO.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: dataA  input  WIDTH  multiplicand, sampled on acceptance.
REQ-005 Port: dataB  input  WIDTH  multiplier, sampled on acceptance.
REQ-006 Port: Signal  input  6  function code; MULTU=6'b011001, MULT=6'b011000, MFHI=6'b010000, MFLO=6'b010010.
REQ-007 Port: dataOut  output  WIDTH  registered HI/LO read result, feeding the ALU result mux alongside the shifter output.
REQ-008 Port: busy  output  1  high while a multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when HI/LO have just been updated.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, Signal==MULTU at a clock edge SHALL accept the operation and go to RUN.
- Load mcand (2*WIDTH bits) = zero-extended dataA.
- Load mplier = dataB.
- Clear product (2*WIDTH bits) and count.
REQ-012 Each RUN cycle SHALL perform one shift-add step and increment count.
- If mplier[0]=1: product += mcand (modulo 2^(2*WIDTH)).
- mcand <<= 1; mplier >>= 1.
REQ-013 On the WIDTH-th RUN cycle, {HI,LO} SHALL be loaded with the final product and the FSM SHALL go to DONE.
REQ-014 DONE SHALL last one cycle, then return to IDLE unless a new MULTU is accepted in that cycle.
REQ-015 busy SHALL be high for exactly WIDTH cycles, starting the cycle after acceptance; done SHALL be high only in DONE.
REQ-016 MULTU or MULT arriving while in RUN SHALL be ignored; the running operation SHALL complete unchanged.
REQ-017 dataOut SHALL register every cycle.
- Signal==MFHI: HI.
- Signal==MFLO: LO.
- Any other code: 0.
- Read latency is one cycle.
REQ-018 MFHI/MFLO issued during RUN SHALL return the HI/LO values from before the operation.
REQ-019 MFHI/MFLO issued in DONE SHALL return the new values.
REQ-020 HI and LO SHALL change only at the end of a completed operation or on reset.

Reset
REQ-021 reset=1 at a clock edge SHALL force: state=IDLE, HI=0, LO=0, product=0, count=0, busy=0, done=0, dataOut=0.
REQ-022 Reset mid-RUN SHALL abort the operation with no HI/LO update; reset SHALL take priority over any Signal.

Configuration
REQ-023 Macro MULT_SIGNED_EN defined: Signal==MULT SHALL be accepted like MULTU, with the following differences.
- The magnitudes of dataA and dataB are loaded as the operands.
- Sign = dataA[WIDTH-1] XOR dataB[WIDTH-1] is latched on acceptance.
- At the HI/LO write, the 2*WIDTH result is two's-complement negated when sign=1.
- Latency is identical to MULTU.
REQ-024 Macro MULT_SIGNED_EN undefined: MULT SHALL be treated as an unrecognised code.
- No acceptance, busy stays 0, HI/LO unchanged.

Verification
REQ-025 Reset, then MULTU dataA=3, dataB=5 -> busy high 32 cycles; done pulse; then MFLO -> 0x0000000F and MFHI -> 0x00000000.
REQ-026 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-027 MULTU 7x6; at RUN cycle 10 drive MULTU 2x2; MFLO during RUN returns the old LO -> final LO=0x0000002A, busy not extended.
REQ-028 MULTU 0x12345678 x 0x10; reset at RUN cycle 16 -> next cycle busy=0, done=0; MFHI and MFLO both read 0.
REQ-029 MULT 0xFFFFFFFE x 3 -> with MULT_SIGNED_EN: HI=0xFFFFFFFF, LO=0xFFFFFFFA; without it: busy stays 0 and HI/LO hold their prior values.
REQ-030 Idle with Signal=6'b000010 (SRL) and HI/LO non-zero -> dataOut=0.
